phys_freelist: RTL and testbench

- Physical-register free list for the rename stage. Sits directly upstream of the speculative arch-to-phys map.
- Supplies the destination physical tag that the map writes on update.
- Reclaims the superseded physical tag (the map's old-phys output, carried to retire) when an instruction commits.
- Holds a speculative head and a committed head, so a pipeline rollback restores the list in the same cycle the map restores from its committed copy.

---
 rtl/phys_freelist_pkg.sv | 17 +
 rtl/phys_freelist_ptr.sv | 23 ++
 rtl/phys_freelist.sv | 128 ++++++++++++
 tb/tb_phys_freelist.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/phys_freelist_pkg.sv
// Shared rename definitions: file sizes, tag width, free-list state encoding
// and the physical tag that every architectural map entry owns after reset.
package phys_freelist_pkg;

    localparam int ARCHFILE_SIZE_DEF = 32;
    localparam int PHYSFILE_SIZE_DEF = 256;
    localparam int TAG_W_DEF         = $clog2(PHYSFILE_SIZE_DEF);

    // Tag held by every map entry out of reset, so the free list never hands it out initially.
    localparam int RESET_PHYS_TAG = 0;

    typedef enum logic {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_e;

endpackage

// File: rtl/phys_freelist_ptr.sv
// Wrapping free-list pointer with an extra wrap bit; load has priority over increment.
module phys_freelist_ptr #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/phys_freelist.sv
// Rename-stage physical register free list with speculative and committed heads,
// so a flush restores the list in the same cycle the map restores its committed copy.
//
// state   | meaning
// FL_INIT | filling entries with tags 1..PHYSFILE_SIZE-1, one per cycle
// FL_RUN  | serving allocations, commits and rollbacks
module phys_freelist
    import phys_freelist_pkg::*;
#(
    parameter  int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF,
    localparam int TAG_W         = $clog2(PHYSFILE_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_phys,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_free_phys,
    input  logic             rollback,
    output logic             ready,
    output logic [TAG_W:0]   free_count,
    output logic             overflow_err
);

    localparam int PTR_W = TAG_W + 1;
    localparam logic [PTR_W-1:0] INIT_LAST  = PTR_W'(PHYSFILE_SIZE - 2);
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(PHYSFILE_SIZE);

    logic [TAG_W-1:0] mem [PHYSFILE_SIZE];

    fl_state_e        state_q;
    fl_state_e        state_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] spec_ptr;
    logic [PTR_W-1:0] cmt_ptr;
    logic [PTR_W-1:0] cmt_next;
    logic             init_wr;
    logic             alloc_do;
    logic             commit_do;
    logic             rollback_do;
    logic             ovf_set;
    logic             full;

    assign free_count  = wr_ptr - spec_ptr;
    assign ready       = (state_q == FL_RUN);
    assign alloc_valid = ready && (free_count != '0);
    assign alloc_phys  = alloc_valid ? mem[spec_ptr[TAG_W-1:0]] : TAG_W'(RESET_PHYS_TAG);
    assign full        = (free_count == FULL_COUNT);
    assign cmt_next    = cmt_ptr + PTR_W'(commit_do);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FL_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_wr     = 1'b0;
        alloc_do    = 1'b0;
        commit_do   = 1'b0;
        rollback_do = 1'b0;
        ovf_set     = 1'b0;
        case (state_q)
            FL_INIT: begin
                // wr_ptr doubles as the init counter: it only advances here during INIT.
                init_wr = 1'b1;
                if (wr_ptr == INIT_LAST) begin
                    state_d = FL_RUN;
                end
            end
            FL_RUN: begin
                rollback_do = rollback;
                alloc_do    = alloc_req && alloc_valid && !rollback;
                commit_do   = commit_valid && !full;
                ovf_set     = commit_valid && full;
            end
            default: state_d = FL_INIT;
        endcase
    end

    phys_freelist_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (init_wr || commit_do),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    phys_freelist_ptr #(.W(PTR_W)) u_spec_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (alloc_do),
        .load     (rollback_do),
        .load_val (cmt_next),
        .ptr      (spec_ptr)
    );

    phys_freelist_ptr #(.W(PTR_W)) u_cmt_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (commit_do),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (cmt_ptr)
    );

    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[wr_ptr[TAG_W-1:0]] <= wr_ptr[TAG_W-1:0] + TAG_W'(1);
        end else if (commit_do) begin
            mem[wr_ptr[TAG_W-1:0]] <= commit_free_phys;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err <= 1'b0;
        end else if (ovf_set) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phys_freelist.sv
// Scoreboard bench for phys_freelist: a queue-based free-list model predicts the
// outputs of every cycle; a monitor on the falling edge compares them against the DUT.
module tb_phys_freelist;

    typedef struct {
        int ready;
        int av;
        int phys;
        int fc;
        int ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [7:0] alloc_phys;
    logic       commit_valid;
    logic [7:0] commit_free_phys;
    logic       rollback;
    logic       ready;
    logic [8:0] free_count;
    logic       overflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];

    // Model: spec_q = tags from speculative head to tail, cmt_q = from committed head to tail.
    int spec_q[$];
    int cmt_q[$];
    bit m_ready;
    bit m_ovf;
    int m_init;

    phys_freelist dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req        (alloc_req),
        .alloc_valid      (alloc_valid),
        .alloc_phys       (alloc_phys),
        .commit_valid     (commit_valid),
        .commit_free_phys (commit_free_phys),
        .rollback         (rollback),
        .ready            (ready),
        .free_count       (free_count),
        .overflow_err     (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_ready", int'(ready), e.ready);
                chk("mon_alloc_valid", int'(alloc_valid), e.av);
                chk("mon_alloc_phys", int'(alloc_phys), e.phys);
                chk("mon_free_count", int'(free_count), e.fc);
                chk("mon_overflow", int'(overflow_err), e.ovf);
            end
        end
    end

    task automatic model_reset();
        spec_q.delete();
        cmt_q.delete();
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        m_init  = 0;
    endtask

    task automatic step(input bit a, input bit c, input int tag, input bit rb);
        exp_t e;
        int   fc;
        bit   do_alloc;
        bit   ovf_now;
        alloc_req        = a;
        commit_valid     = c;
        commit_free_phys = 8'(tag);
        rollback         = rb;
        fc      = spec_q.size();
        e.ready = int'(m_ready);
        e.av    = (m_ready && fc != 0) ? 1 : 0;
        e.phys  = (e.av == 1) ? spec_q[0] : 0;
        e.fc    = fc;
        e.ovf   = int'(m_ovf);
        exp_q.push_back(e);
        if (!m_ready) begin
            spec_q.push_back(m_init + 1);
            cmt_q.push_back(m_init + 1);
            m_init++;
            if (m_init == 255) m_ready = 1'b1;
        end else begin
            do_alloc = a && (e.av == 1) && !rb;
            ovf_now  = c && (fc == 256);
            if (do_alloc) void'(spec_q.pop_front());
            if (c && !ovf_now) begin
                spec_q.push_back(tag);
                cmt_q.push_back(tag);
                void'(cmt_q.pop_front());
            end
            if (ovf_now) m_ovf = 1'b1;
            if (rb) spec_q = cmt_q;
        end
        @(posedge clk);
        #1;
        alloc_req    = 1'b0;
        commit_valid = 1'b0;
        rollback     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_alloc_valid"}, int'(alloc_valid), 0);
        chk({tag, "_alloc_phys"}, int'(alloc_phys), 0);
        chk({tag, "_free_count"}, int'(free_count), 0);
        chk({tag, "_overflow"}, int'(overflow_err), 0);
    endtask

    // Assert reset mid-cycle, check outputs drop at once, release, and time INIT.
    task automatic do_reset(input string tag);
        int n;
        rst = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        while (!ready && n < 400) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk({tag, "_init_cycles"}, n, 255);
        chk({tag, "_ready_fc"}, int'(free_count), 255);
        chk({tag, "_ready_av"}, int'(alloc_valid), 1);
        chk({tag, "_ready_phys"}, int'(alloc_phys), 1);
    endtask

    initial begin
        rst              = 1'b0;
        alloc_req        = 1'b0;
        commit_valid     = 1'b0;
        commit_free_phys = '0;
        rollback         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset, idle until ready, then three back-to-back allocations.
        do_reset("rst0");
        for (int k = 1; k <= 3; k++) begin
            chk("alloc3_phys", int'(alloc_phys), k);
            step(1, 0, 0, 0);
        end
        chk("alloc3_fc", int'(free_count), 252);
        chk("alloc3_next", int'(alloc_phys), 4);

        // Rollback with two commits in flight and a dropped same-cycle alloc.
        do_reset("rst_rb");
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(1, 0, 0, 1);
        chk("rollback_phys", int'(alloc_phys), 3);
        chk("rollback_fc", int'(free_count), 255);

        // Drain to empty, stall, then a single free becomes the head.
        do_reset("rst_drain");
        for (int k = 0; k < 255; k++) step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("empty_av", int'(alloc_valid), 0);
            chk("empty_phys", int'(alloc_phys), 0);
            chk("empty_fc", int'(free_count), 0);
            step(1, 0, 0, 0);
        end
        step(0, 1, 7, 0);
        chk("refill_av", int'(alloc_valid), 1);
        chk("refill_phys", int'(alloc_phys), 7);
        chk("refill_fc", int'(free_count), 1);

        // Steady alloc+commit past the wrap point, then fill and overflow.
        do_reset("rst_wrap");
        for (int k = 0; k < 600; k++) step(1, 1, int'($urandom_range(0, 255)), 0);
        chk("wrap_fc", int'(free_count), 255);
        chk("wrap_ovf", int'(overflow_err), 0);
        step(0, 1, 9, 0);
        chk("fill_fc", int'(free_count), 256);
        chk("fill_ovf", int'(overflow_err), 0);
        step(0, 1, 11, 0);
        chk("ovf_set", int'(overflow_err), 1);
        chk("ovf_fc", int'(free_count), 256);
        step(0, 0, 0, 0);
        chk("ovf_sticky", int'(overflow_err), 1);

        // Reset from RUN clears the sticky error; reset again mid-INIT restarts the fill.
        rst = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("rst_run");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 100; k++) step(0, 0, 0, 0);
        chk("mid_init_fc", int'(free_count), 100);
        do_reset("rst_mid_init");

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit a;
            bit c;
            bit rb;
            a  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 1) == 1) && (spec_q.size() < 256);
            rb = ($urandom_range(0, 31) == 0);
            step(a, c, int'($urandom_range(0, 255)), rb);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
